fb_write_arbiter: RTL and testbench

//  Shares the single write port of the 256x256x8 frame buffer between three sources:
//   the flash loader stream, a host/draw requester with req/ack, and a built-in clear engine.

---
 rtl/fb_write_arbiter_pkg.sv | 29 ++
 rtl/fb_wr_fifo.sv | 52 +++++
 rtl/fb_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the frame-buffer write arbiter.
//   FB_AW / FB_DW          : frame buffer address / data width
//   *_DEF                  : default arbiter parameters
//   CLR_IDLE / CLR_RUN     : clear-engine state encodings
//   src_e                  : arbiter source codes (winner of a write slot)
//   fb_wr_t                : one frame-buffer write (address + data)
package fb_write_arbiter_pkg;

  localparam int unsigned FB_AW             = 16;
  localparam int unsigned FB_DW             = 8;
  localparam int unsigned LD_FIFO_DEPTH_DEF = 4;
  localparam int unsigned HOST_MAX_WAIT_DEF = 8;

  localparam logic [0:0] CLR_IDLE = 1'b0;
  localparam logic [0:0] CLR_RUN  = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HOST = 2'd1,
    SRC_LD   = 2'd2,
    SRC_CLR  = 2'd3
  } src_e;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Loader write FIFO: synchronous, DEPTH entries of fb_wr_t.
//   clk, rst   : clock, async active-low reset (empties the FIFO)
//   push/wdata : write strobe and entry; dropped when full unless popping too
//   pop/rdata  : read strobe and head entry (rdata valid while !empty)
//   full/empty : occupancy flags
module fb_wr_fifo
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = LD_FIFO_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  fb_wr_t wdata,
  input  logic   pop,
  output fb_wr_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  fb_wr_t         mem [DEPTH];
  logic   [PW:0]  wr_ptr;
  logic   [PW:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame buffer write port between the flash loader (via FIFO),
// a req/ack host and the built-in clear engine.
//   clk, rst                   : clock, async active-low reset
//   ld_en/ld_ad/ld_wd          : loader write stream, never stalled
//   host_req/host_ad/host_wd   : host write request, held until host_ack
//   host_ack                   : one-cycle pulse alongside the host write
//   clr_start/clr_color        : start a full-buffer clear with this colour
//   clr_busy                   : clear in progress
//   ld_ovf                     : sticky, a loader write was dropped
//   b_w_en/b_w_ad/b_w_wd       : registered frame buffer write port
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEF,
  parameter int unsigned HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [FB_AW-1:0] ld_ad,
  input  logic [FB_DW-1:0] ld_wd,
  input  logic             host_req,
  input  logic [FB_AW-1:0] host_ad,
  input  logic [FB_DW-1:0] host_wd,
  output logic             host_ack,
  input  logic             clr_start,
  input  logic [FB_DW-1:0] clr_color,
  output logic             clr_busy,
  output logic             ld_ovf,
  output logic             b_w_en,
  output logic [FB_AW-1:0] b_w_ad,
  output logic [FB_DW-1:0] b_w_wd
);

  localparam int unsigned WW = $clog2(HOST_MAX_WAIT + 2);

  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_cnt_nxt;
  logic [0:0]       clr_state;
  logic [0:0]       clr_state_nxt;
  logic [FB_AW-1:0] clr_addr;
  logic [FB_AW-1:0] clr_addr_nxt;
  logic [FB_DW-1:0] clr_col;
  logic [FB_DW-1:0] clr_col_nxt;
  logic             host_pend;
  logic             host_forced;
  logic             ld_pop;
  logic             fifo_full;
  logic             fifo_empty;
  fb_wr_t           ld_head;
  fb_wr_t           sel;
  src_e             src;

  fb_wr_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_en),
    .wdata ({ld_ad, ld_wd}),
    .pop   (ld_pop),
    .rdata (ld_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A host already acked this cycle is not granted again.
  assign host_pend   = host_req && !host_ack;
  assign host_forced = host_pend && (wait_cnt == WW'(HOST_MAX_WAIT));
  assign ld_pop      = (src == SRC_LD);
  assign clr_busy    = (clr_state == CLR_RUN);

  // Fixed-priority slot arbitration.
  always_comb begin
    src = SRC_NONE;
    sel = '0;
    if (host_forced) begin
      src = SRC_HOST;
      sel = {host_ad, host_wd};
    end else if (!fifo_empty) begin
      src = SRC_LD;
      sel = ld_head;
    end else if (host_pend) begin
      src = SRC_HOST;
      sel = {host_ad, host_wd};
    end else if (clr_state == CLR_RUN) begin
      src = SRC_CLR;
      sel = {clr_addr, clr_col};
    end
  end

  // Host wait counter: saturating, cleared on grant or when host idles.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!host_req || (src == SRC_HOST)) begin
      wait_cnt_nxt = '0;
    end else if (!host_ack && (wait_cnt != WW'(HOST_MAX_WAIT))) begin
      wait_cnt_nxt = wait_cnt + WW'(1);
    end
  end

  // Clear engine next state; advances only on slots it wins.
  always_comb begin
    clr_state_nxt = clr_state;
    clr_addr_nxt  = clr_addr;
    clr_col_nxt   = clr_col;
    case (clr_state)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_nxt = CLR_RUN;
          clr_addr_nxt  = '0;
          clr_col_nxt   = clr_color;
        end
      end
      CLR_RUN: begin
        if (src == SRC_CLR) begin
          clr_addr_nxt = clr_addr + FB_AW'(1);
          if (clr_addr == '1) clr_state_nxt = CLR_IDLE;
        end
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_col   <= '0;
      ld_ovf    <= 1'b0;
      host_ack  <= 1'b0;
      b_w_en    <= 1'b0;
      b_w_ad    <= '0;
      b_w_wd    <= '0;
    end else begin
      wait_cnt  <= wait_cnt_nxt;
      clr_state <= clr_state_nxt;
      clr_addr  <= clr_addr_nxt;
      clr_col   <= clr_col_nxt;
      ld_ovf    <= ld_ovf || (ld_en && fifo_full && !ld_pop);
      host_ack  <= (src == SRC_HOST);
      b_w_en    <= (src != SRC_NONE);
      b_w_ad    <= sel.addr;
      b_w_wd    <= sel.data;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed stimulus, a transaction-level model
// queues every expected write with its due cycle, and a monitor compares.
module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int unsigned TB_DEPTH = 4;
  localparam int unsigned TB_HMW   = 2;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             ld_en     = 1'b0;
  logic [FB_AW-1:0] ld_ad     = '0;
  logic [FB_DW-1:0] ld_wd     = '0;
  logic             host_req  = 1'b0;
  logic [FB_AW-1:0] host_ad   = '0;
  logic [FB_DW-1:0] host_wd   = '0;
  logic             host_ack;
  logic             clr_start = 1'b0;
  logic [FB_DW-1:0] clr_color = '0;
  logic             clr_busy;
  logic             ld_ovf;
  logic             b_w_en;
  logic [FB_AW-1:0] b_w_ad;
  logic [FB_DW-1:0] b_w_wd;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .LD_FIFO_DEPTH (TB_DEPTH),
    .HOST_MAX_WAIT (TB_HMW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .ld_ad     (ld_ad),
    .ld_wd     (ld_wd),
    .host_req  (host_req),
    .host_ad   (host_ad),
    .host_wd   (host_wd),
    .host_ack  (host_ack),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .ld_ovf    (ld_ovf),
    .b_w_en    (b_w_en),
    .b_w_ad    (b_w_ad),
    .b_w_wd    (b_w_wd)
  );

  typedef struct {
    int          due;
    logic [15:0] ad;
    logic [7:0]  wd;
    logic        ack;
  } exp_t;

  exp_t        exp_q[$];
  fb_wr_t      m_fifo[$];
  int unsigned m_wait  = 0;
  logic        m_ack   = 1'b0;
  logic        m_run   = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_caddr = '0;
  logic [7:0]  m_ccol  = '0;
  int          cyc     = 0;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  fb_mem [0:65535];
  int          writes_seen   = 0;
  int          last_ffff_cyc = -1;
  int          busy_fall_cyc = -2;
  logic        prev_busy     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected-write predictor, stepped on every active clock edge.
  always @(posedge clk or negedge rst) begin : model
    int     win;
    exp_t   e;
    fb_wr_t h;
    if (!rst) begin
      exp_q.delete();
      m_fifo.delete();
      m_wait  = 0;
      m_ack   = 1'b0;
      m_run   = 1'b0;
      m_ovf   = 1'b0;
      m_caddr = '0;
      m_ccol  = '0;
    end else begin
      cyc   = cyc + 1;
      win   = 0;
      e.due = cyc;
      e.ad  = '0;
      e.wd  = '0;
      e.ack = 1'b0;
      if (host_req && !m_ack && m_wait == TB_HMW) win = 1;
      else if (m_fifo.size() != 0)               win = 2;
      else if (host_req && !m_ack)               win = 1;
      else if (m_run)                            win = 3;
      case (win)
        1: begin e.ad = host_ad; e.wd = host_wd; e.ack = 1'b1; end
        2: begin h = m_fifo.pop_front(); e.ad = h.addr; e.wd = h.data; end
        3: begin e.ad = m_caddr; e.wd = m_ccol; end
        default: ;
      endcase
      if (win != 0) exp_q.push_back(e);
      if (ld_en) begin
        if (m_fifo.size() < TB_DEPTH) m_fifo.push_back(fb_wr_t'({ld_ad, ld_wd}));
        else                          m_ovf = 1'b1;
      end
      if (!host_req || win == 1)                 m_wait = 0;
      else if (!m_ack && m_wait < TB_HMW)        m_wait = m_wait + 1;
      if (!m_run) begin
        if (clr_start) begin
          m_run   = 1'b1;
          m_caddr = '0;
          m_ccol  = clr_color;
        end
      end else if (win == 3) begin
        if (m_caddr == 16'hFFFF) m_run = 1'b0;
        m_caddr = m_caddr + 16'd1;
      end
      m_ack = (win == 1);
    end
  end

  // Monitor: compares DUT write port and status against the model.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      total++;
      if (clr_busy !== m_run) begin
        bad++;
        $display("FAIL clr_busy cyc=%0d actual=%b required=%b", cyc, clr_busy, m_run);
      end
      total++;
      if (ld_ovf !== m_ovf) begin
        bad++;
        $display("FAIL ld_ovf cyc=%0d actual=%b required=%b", cyc, ld_ovf, m_ovf);
      end
      if (b_w_en) begin
        writes_seen++;
        fb_mem[b_w_ad] = b_w_wd;
        if (b_w_ad == 16'hFFFF) last_ffff_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stray_write cyc=%0d actual ad=%h wd=%h ack=%b required none",
                   cyc, b_w_ad, b_w_wd, host_ack);
        end else begin
          e = exp_q.pop_front();
          if (e.due != cyc || e.ad !== b_w_ad || e.wd !== b_w_wd || e.ack !== host_ack) begin
            bad++;
            $display("FAIL write cyc=%0d actual ad=%h wd=%h ack=%b required cyc=%0d ad=%h wd=%h ack=%b",
                     cyc, b_w_ad, b_w_wd, host_ack, e.due, e.ad, e.wd, e.ack);
          end
        end
      end else if (host_ack || (exp_q.size() != 0 && exp_q[0].due <= cyc)) begin
        total++;
        bad++;
        $display("FAIL missing_write cyc=%0d actual en=0 ack=%b required a write", cyc, host_ack);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
      end
      if (prev_busy && !clr_busy) busy_fall_cyc = cyc;
      prev_busy = clr_busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one host write; lat counts edges until host_ack is seen.
  task automatic host_write(input logic [15:0] a, input logic [7:0] d, output int lat);
    host_req = 1'b1;
    host_ad  = a;
    host_wd  = d;
    lat      = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (host_ack) break;
      if (lat >= 200) begin
        total++;
        bad++;
        $display("FAIL host_ack_timeout actual=no ack after %0d required=ack", lat);
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic loader_stream(input int n, input logic [15:0] base, input logic [7:0] dbase);
    for (int i = 0; i < n; i++) begin
      ld_en = 1'b1;
      ld_ad = base + 16'(i);
      ld_wd = dbase + 8'(i);
      step(1);
    end
    ld_en = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin : main
    int lat;
    int errs;
    int guard;

    // Reset state
    step(3);
    check("rst_b_w_en", 32'(b_w_en), 32'h0);
    check("rst_b_w_ad", 32'(b_w_ad), 32'h0);
    check("rst_b_w_wd", 32'(b_w_wd), 32'h0);
    check("rst_host_ack", 32'(host_ack), 32'h0);
    check("rst_clr_busy", 32'(clr_busy), 32'h0);
    check("rst_ld_ovf", 32'(ld_ovf), 32'h0);
    rst = 1'b1;
    step(2);

    // Loader burst: entries appear two cycles after their strobe, in order
    ld_en = 1'b1; ld_ad = 16'h0000; ld_wd = 8'h11;
    step(1);
    check("burst_c1_en", 32'(b_w_en), 32'h0);
    ld_ad = 16'h0001; ld_wd = 8'h22;
    step(1);
    check("burst_c2", {7'd0, b_w_en, b_w_ad, b_w_wd}, {7'd0, 1'b1, 16'h0000, 8'h11});
    ld_ad = 16'h0002; ld_wd = 8'h33;
    step(1);
    ld_en = 1'b0;
    check("burst_c3", {7'd0, b_w_en, b_w_ad, b_w_wd}, {7'd0, 1'b1, 16'h0001, 8'h22});
    step(1);
    check("burst_c4", {7'd0, b_w_en, b_w_ad, b_w_wd}, {7'd0, 1'b1, 16'h0002, 8'h33});
    step(1);
    check("burst_c5_en", 32'(b_w_en), 32'h0);

    // Uncontended host write is acked one cycle after the request
    host_write(16'h0100, 8'h77, lat);
    check("host_free_lat", 32'(lat), 32'd1);
    check("host_free_ad", 32'(b_w_ad), 32'h0100);
    check("host_free_wd", 32'(b_w_wd), 32'h77);
    step(2);

    // Overflow: continuous loader while the host keeps stealing forced slots
    fork
      loader_stream(40, 16'h4000, 8'h80);
      begin
        for (int i = 0; i < 8; i++) begin
          host_write(16'h2000 + 16'(i), 8'hC0 + 8'(i), lat);
          step(1);
        end
      end
    join
    step(10);
    check("ovf_set", 32'(ld_ovf), 32'h1);
    step(5);
    check("ovf_sticky", 32'(ld_ovf), 32'h1);

    // Host starvation bound under a continuous loader stream
    pulse_reset();
    check("ovf_cleared", 32'(ld_ovf), 32'h0);
    fork
      loader_stream(30, 16'h6000, 8'h10);
      begin
        step(3);
        host_write(16'h1234, 8'hAB, lat);
        check("starve_lat_bound", 32'(lat <= int'(TB_HMW) + 2), 32'h1);
        check("starve_ad", 32'(b_w_ad), 32'h1234);
        check("starve_wd", 32'(b_w_wd), 32'hAB);
      end
    join
    step(10);

    // Reset in the middle of a clear
    clr_color = 8'h3C; clr_start = 1'b1;
    step(1);
    clr_start = 1'b0;
    step(100);
    check("midclr_busy", 32'(clr_busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("midclr_rst_en", 32'(b_w_en), 32'h0);
    check("midclr_rst_busy", 32'(clr_busy), 32'h0);
    check("midclr_rst_ovf", 32'(ld_ovf), 32'h0);
    check("midclr_rst_ack", 32'(host_ack), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    writes_seen = 0;
    step(20);
    check("midclr_no_writes", 32'(writes_seen), 32'h0);
    check("midclr_idle", 32'(clr_busy), 32'h0);

    // Full clear with a host write landing behind the clear front
    clr_color = 8'hE0; clr_start = 1'b1;
    step(1);
    clr_start = 1'b0;
    step(30);
    host_write(16'h0005, 8'h5A, lat);
    check("clr_host_lat", 32'(lat), 32'd1);
    clr_color = 8'h11; clr_start = 1'b1;
    step(1);
    clr_start = 1'b0;
    guard = 0;
    while (clr_busy && guard < 70000) begin
      step(1);
      guard++;
    end
    check("clr_done", 32'(clr_busy), 32'h0);
    step(5);
    check("clr_busy_fall_at_last", 32'(busy_fall_cyc == last_ffff_cyc), 32'h1);
    errs = 0;
    for (int a = 0; a < 65536; a++) begin
      if (a == 5) begin
        if (fb_mem[a] !== 8'h5A) errs++;
      end else if (fb_mem[a] !== 8'hE0) begin
        errs++;
      end
    end
    check("fb_contents_errs", 32'(errs), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
